// File: rtl/axi_write_adapter_if.sv
// AXI3 write-channel bundle (AW, W, B) between the CPU write adapter and the interconnect.
interface axi_write_adapter_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_write_adapter.sv
// Single-outstanding AXI3 write master: one MEM-stage store becomes one single-beat AW/W/B transaction.
module axi_write_adapter (
    input  logic                       clk,
    input  logic                       reset,
    axi_write_adapter_if.master        axi,
    input  logic                       mem_we,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_sel,
    output logic                       mem_write_done,
    output logic                       mem_write_error
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2,
        W_DONE = 2'd3
    } state_t;

    state_t state, state_next;
    logic   aw_done, w_done, err_q;
    logic   aw_fire, w_fire, aw_ok, w_ok;

    // kseg0/kseg1 alias onto the low 512 MB of physical space
    function automatic logic [31:0] map_kseg(input logic [31:0] vaddr);
        if (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101)
            map_kseg = {3'b000, vaddr[28:0]};
        else
            map_kseg = vaddr;
    endfunction

    assign axi.awid    = 4'b0;
    assign axi.awlen   = 4'b0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b0;
    assign axi.awcache = 4'b0;
    assign axi.awprot  = 3'b001;
    assign axi.wid     = 4'b0;
    assign axi.wlast   = axi.wvalid;

    assign aw_fire = axi.awvalid && axi.awready;
    assign w_fire  = axi.wvalid && axi.wready;
    assign aw_ok   = aw_done || aw_fire;
    assign w_ok    = w_done || w_fire;

    always_ff @(posedge clk) begin
        if (reset)
            state <= W_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            W_IDLE: if (mem_we) state_next = W_SEND;
            W_SEND: if (aw_ok && w_ok) state_next = W_RESP;
            W_RESP: if (axi.bvalid) state_next = W_DONE;
            W_DONE: state_next = W_IDLE;
            default: state_next = W_IDLE;
        endcase
    end

    always_comb begin
        axi.bready      = (state == W_RESP);
        mem_write_done  = (state == W_DONE);
        mem_write_error = (state == W_DONE) && err_q;
    end

    // Channel registers: captured once in W_IDLE, frozen until the next capture
    always_ff @(posedge clk) begin
        if (reset) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.awaddr  <= 32'b0;
            axi.wdata   <= 32'b0;
            axi.wstrb   <= 4'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (mem_we) begin
                        axi.awaddr  <= map_kseg(mem_addr);
                        axi.wdata   <= mem_wdata;
                        axi.wstrb   <= mem_sel;
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                    end
                end
                W_SEND: begin
                    if (aw_fire) begin
                        axi.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_fire) begin
                        axi.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (axi.bvalid)
                        err_q <= (axi.bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

endmodule
